// File: rtl/scmp_ifetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scmp_ifetch_if : byte read bus + instruction handoff of the fetch unit|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface scmp_ifetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_op;
  logic [7:0]  ins_disp;
  logic        ins_two;

  // master = fetch unit; slave = memory responder plus sequencer
  modport master (
    output mem_req, mem_addr,
    input  mem_rdata, mem_ack,
    output ins_valid, ins_op, ins_disp, ins_two,
    input  ins_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rdata, mem_ack,
    input  ins_valid, ins_op, ins_disp, ins_two,
    output ins_ready
  );
endinterface
`default_nettype wire

// File: rtl/scmp_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scmp_ifetch : SC/MP instruction fetch, pre-increment PC with 4K page |
// |               wrap, 1/2-byte fetch, valid/ready handoff to sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scmp_ifetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        fetch_en,
  input  wire logic        pc_load,
  input  wire logic [15:0] pc_load_val,
  output logic      [15:0] pc,
  scmp_ifetch_if.master    bus
);

  localparam logic [2:0] C_IDLE    = 3'd0;
  localparam logic [2:0] C_RD_OP   = 3'd1;
  localparam logic [2:0] C_RD_DISP = 3'd2;
  localparam logic [2:0] C_HOLD    = 3'd3;
  localparam logic [2:0] C_DRAIN   = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] r_mem_addr;
  logic        r_mem_req;
  logic        r_ins_valid;
  logic [7:0]  r_ins_op;
  logic [7:0]  r_ins_disp;
  logic        r_ins_two;

  logic        w_mem_req_nxt;
  logic        w_ins_valid_nxt;
  logic        w_inc;
  logic        w_cap_op;
  logic        w_cap_disp;
  logic [15:0] w_pc_inc;

  // Increment carries only within the low 12 bits; the page nibble is fixed
  assign w_pc_inc = {r_pc[15:12], r_pc[11:0] + 12'd1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= C_IDLE;
      r_mem_req   <= 1'b0;
      r_ins_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_ins_valid <= w_ins_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE: begin
        if (!pc_load && fetch_en) w_state_nxt = C_RD_OP;
      end
      C_RD_OP: begin
        // A jump abandons the fetch but the bus cycle must still complete
        if (pc_load)           w_state_nxt = bus.mem_ack ? C_IDLE : C_DRAIN;
        else if (bus.mem_ack)  w_state_nxt = bus.mem_rdata[7] ? C_RD_DISP : C_HOLD;
      end
      C_RD_DISP: begin
        if (pc_load)           w_state_nxt = bus.mem_ack ? C_IDLE : C_DRAIN;
        else if (bus.mem_ack)  w_state_nxt = C_HOLD;
      end
      C_HOLD: begin
        if (bus.ins_ready) w_state_nxt = C_IDLE;
      end
      C_DRAIN: begin
        if (bus.mem_ack) w_state_nxt = C_IDLE;
      end
      default: w_state_nxt = C_IDLE;
    endcase
  end

  always_comb begin
    w_inc           = 1'b0;
    w_cap_op        = 1'b0;
    w_cap_disp      = 1'b0;
    w_mem_req_nxt   = (w_state_nxt == C_RD_OP) || (w_state_nxt == C_RD_DISP) ||
                      (w_state_nxt == C_DRAIN);
    w_ins_valid_nxt = (w_state_nxt == C_HOLD);
    case (r_state)
      C_IDLE:    w_inc = !pc_load && fetch_en;
      C_RD_OP: begin
        w_cap_op = !pc_load && bus.mem_ack;
        w_inc    = !pc_load && bus.mem_ack && bus.mem_rdata[7];
      end
      C_RD_DISP: w_cap_disp = !pc_load && bus.mem_ack;
      default:   w_inc = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_ins_op   <= 8'h00;
      r_ins_disp <= 8'h00;
      r_ins_two  <= 1'b0;
    end else begin
      if (pc_load)    r_pc <= pc_load_val;
      else if (w_inc) r_pc <= w_pc_inc;
      // mem_addr follows only issued requests, so a drained read keeps its address
      if (w_inc)      r_mem_addr <= w_pc_inc;
      if (w_cap_op) begin
        r_ins_op  <= bus.mem_rdata;
        r_ins_two <= bus.mem_rdata[7];
        if (!bus.mem_rdata[7]) r_ins_disp <= 8'h00;
      end
      if (w_cap_disp) r_ins_disp <= bus.mem_rdata;
    end
  end

  assign pc            = r_pc;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.ins_valid = r_ins_valid;
  assign bus.ins_op    = r_ins_op;
  assign bus.ins_disp  = r_ins_disp;
  assign bus.ins_two   = r_ins_two;

endmodule
`default_nettype wire

// File: tb/tb_scmp_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scmp_ifetch : vector table, corner sequences and random fetches   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_scmp_ifetch;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [15:0] pc;

  scmp_ifetch_if bus ();

  scmp_ifetch #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .pc          (pc),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:65535];
  int          wait_cfg = 0;
  logic        stray_ack = 1'b0;
  int          resp_wc = 0;
  logic [15:0] bus_log [$];

  typedef struct {
    logic [15:0] pc0;
    logic [7:0]  op;
    logic [7:0]  disp;
    int          waits;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [7:0]  eop;
    logic [7:0]  edisp;
    logic        etwo;
    logic [15:0] epc;
  } vec_t;

  vec_t vecs [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Memory slave: wait_cfg idle cycles before each ack, addresses logged at ack
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && rst_n === 1'b1) begin
        if (resp_wc >= wait_cfg) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
          bus_log.push_back(bus.mem_addr);
          resp_wc = 0;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 8'hA5;
          resp_wc++;
        end
      end else begin
        bus.mem_ack   = stray_ack;
        bus.mem_rdata = 8'hFF;
        resp_wc = 0;
      end
    end
  end

  function automatic logic [15:0] page_inc(input logic [15:0] a);
    return (a & 16'hF000) | ((a + 16'd1) & 16'h0FFF);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_load     = 1'b1;
    pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
    chk("load_pc", pc, v);
  endtask

  // Starts a fetch from IDLE and waits (bounded) for the instruction
  task automatic run_fetch(input string nm, input int waits,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input logic [7:0] eop, input logic [7:0] edisp,
                           input logic etwo, input logic [15:0] epc);
    int cyc;
    int lat;
    wait_cfg = waits;
    bus_log.delete();
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk({nm, " req"}, bus.mem_req, 1);
    chk({nm, " addr0"}, bus.mem_addr, a0);
    cyc = 1;
    while (bus.ins_valid !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    lat = 1 + (etwo ? 2 : 1) * (waits + 1);
    chk({nm, " latency"}, cyc, lat);
    chk({nm, " op"}, bus.ins_op, eop);
    chk({nm, " disp"}, bus.ins_disp, edisp);
    chk({nm, " two"}, bus.ins_two, etwo);
    chk({nm, " pc"}, pc, epc);
    chk({nm, " req_off"}, bus.mem_req, 0);
    chk({nm, " nreads"}, bus_log.size(), etwo ? 2 : 1);
    if (bus_log.size() > 0) chk({nm, " log0"}, bus_log[0], a0);
    if (etwo && bus_log.size() > 1) chk({nm, " log1"}, bus_log[1], a1);
  endtask

  task automatic accept();
    bus.ins_ready = 1'b1;
    @(negedge clk);
    bus.ins_ready = 1'b0;
    chk("accept valid", bus.ins_valid, 0);
    chk("accept req", bus.mem_req, 0);
  endtask

  initial begin
    logic [15:0] p, a0, a1;
    logic [7:0]  op, d;
    int          w;
    int          n;
    logic        saw_valid;

    rst_n         = 1'b0;
    fetch_en      = 1'b0;
    pc_load       = 1'b0;
    pc_load_val   = 16'h0000;
    bus.ins_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst pc", pc, 16'h0000);
    chk("rst req", bus.mem_req, 0);
    chk("rst addr", bus.mem_addr, 16'h0000);
    chk("rst valid", bus.ins_valid, 0);
    chk("rst op", bus.ins_op, 0);
    chk("rst disp", bus.ins_disp, 0);
    chk("rst two", bus.ins_two, 0);

    //           pc0       op     disp  w  a0        a1        eop    edisp  two   epc
    vecs[0] = '{16'h0000, 8'h08, 8'h00, 0, 16'h0001, 16'h0002, 8'h08, 8'h00, 1'b0, 16'h0001};
    vecs[1] = '{16'h0001, 8'hC4, 8'h55, 2, 16'h0002, 16'h0003, 8'hC4, 8'h55, 1'b1, 16'h0003};
    vecs[2] = '{16'h2FFF, 8'h8F, 8'h10, 0, 16'h2000, 16'h2001, 8'h8F, 8'h10, 1'b1, 16'h2001};
    vecs[3] = '{16'h1FFE, 8'h90, 8'h7A, 1, 16'h1FFF, 16'h1000, 8'h90, 8'h7A, 1'b1, 16'h1000};
    vecs[4] = '{16'hFFFF, 8'h7F, 8'h33, 3, 16'hF000, 16'hF001, 8'h7F, 8'h00, 1'b0, 16'hF000};
    vecs[5] = '{16'hABCD, 8'h80, 8'hFF, 0, 16'hABCE, 16'hABCF, 8'h80, 8'hFF, 1'b1, 16'hABCF};

    for (int i = 0; i < 6; i++) begin
      mem[vecs[i].a0] = vecs[i].op;
      mem[vecs[i].a1] = vecs[i].disp;
      load_pc(vecs[i].pc0);
      run_fetch($sformatf("vec%0d", i), vecs[i].waits, vecs[i].a0, vecs[i].a1,
                vecs[i].eop, vecs[i].edisp, vecs[i].etwo, vecs[i].epc);
      accept();
    end

    // Stall in HOLD, then jump in HOLD, then accept with fetch_en already high
    load_pc(16'h3000);
    mem[16'h3001] = 8'hC0;
    mem[16'h3002] = 8'h42;
    run_fetch("hold", 1, 16'h3001, 16'h3002, 8'hC0, 8'h42, 1'b1, 16'h3002);
    repeat (5) begin
      @(negedge clk);
      chk("hold valid", bus.ins_valid, 1);
      chk("hold op", bus.ins_op, 8'hC0);
      chk("hold disp", bus.ins_disp, 8'h42);
    end
    pc_load     = 1'b1;
    pc_load_val = 16'h4000;
    @(negedge clk);
    pc_load = 1'b0;
    chk("hold load pc", pc, 16'h4000);
    chk("hold load valid", bus.ins_valid, 1);
    chk("hold load op", bus.ins_op, 8'hC0);
    mem[16'h4001] = 8'h01;
    wait_cfg = 0;
    bus_log.delete();
    bus.ins_ready = 1'b1;
    fetch_en      = 1'b1;
    @(negedge clk);
    bus.ins_ready = 1'b0;
    chk("acc cycle valid", bus.ins_valid, 0);
    chk("acc cycle req", bus.mem_req, 0);
    @(negedge clk);
    fetch_en = 1'b0;
    chk("refetch req", bus.mem_req, 1);
    chk("refetch addr", bus.mem_addr, 16'h4001);
    @(negedge clk);
    chk("refetch valid", bus.ins_valid, 1);
    chk("refetch op", bus.ins_op, 8'h01);
    chk("refetch two", bus.ins_two, 0);

    // Jump and accept in the same cycle
    pc_load       = 1'b1;
    pc_load_val   = 16'h5555;
    bus.ins_ready = 1'b1;
    @(negedge clk);
    pc_load       = 1'b0;
    bus.ins_ready = 1'b0;
    chk("ld+rdy pc", pc, 16'h5555);
    chk("ld+rdy valid", bus.ins_valid, 0);

    // Stray acks with no request
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    chk("stray req", bus.mem_req, 0);
    chk("stray valid", bus.ins_valid, 0);
    chk("stray pc", pc, 16'h5555);

    // Jump while a slow opcode read is outstanding
    load_pc(16'h0FF0);
    mem[16'h0FF1] = 8'h33;
    wait_cfg = 3;
    bus_log.delete();
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en    = 1'b0;
    pc_load     = 1'b1;
    pc_load_val = 16'h1234;
    @(negedge clk);
    pc_load = 1'b0;
    chk("drain pc", pc, 16'h1234);
    chk("drain req", bus.mem_req, 1);
    chk("drain addr", bus.mem_addr, 16'h0FF1);
    saw_valid = 1'b0;
    n = 0;
    while (bus.mem_req === 1'b1 && n < 20) begin
      if (bus.ins_valid !== 1'b0) saw_valid = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("drain done", bus.mem_req, 0);
    chk("drain cycles", n, 3);
    chk("drain no valid", saw_valid, 0);
    @(negedge clk);
    chk("drain after valid", bus.ins_valid, 0);
    chk("drain after pc", pc, 16'h1234);
    chk("drain reads", bus_log.size(), 1);
    mem[16'h1235] = 8'h02;
    run_fetch("postdrain", 0, 16'h1235, 16'h1236, 8'h02, 8'h00, 1'b0, 16'h1235);
    accept();

    // Asynchronous reset while the displacement read is pending
    mem[16'h1236] = 8'h84;
    mem[16'h1237] = 8'h11;
    wait_cfg = 3;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    n = 0;
    while (bus.mem_addr !== 16'h1237 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_disp reached", bus.mem_addr, 16'h1237);
    chk("rd_disp req", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst req", bus.mem_req, 0);
    chk("arst valid", bus.ins_valid, 0);
    chk("arst pc", pc, 16'h0000);
    chk("arst addr", bus.mem_addr, 16'h0000);
    chk("arst op", bus.ins_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst idle req", bus.mem_req, 0);
    mem[16'h0001] = 8'h08;
    run_fetch("after_rst", 0, 16'h0001, 16'h0002, 8'h08, 8'h00, 1'b0, 16'h0001);
    accept();

    // Random fetches against the rule-based model
    for (int k = 0; k < 16; k++) begin
      p  = 16'($urandom);
      w  = $urandom_range(0, 3);
      op = 8'($urandom);
      d  = 8'($urandom);
      a0 = page_inc(p);
      a1 = page_inc(a0);
      mem[a0] = op;
      mem[a1] = d;
      load_pc(p);
      run_fetch($sformatf("rnd%0d", k), w, a0, a1, op,
                (op >= 8'h80) ? d : 8'h00, op >= 8'h80,
                (op >= 8'h80) ? a1 : a0);
      n = $urandom_range(0, 3);
      repeat (n) begin
        @(negedge clk);
        chk("rnd stall valid", bus.ins_valid, 1);
      end
      accept();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
